// File: rtl/arb_cycle_tracer_pkg.sv
// Shared types and defaults for the arbitrage cycle tracer.
// Vertex word layout, FSM encoding and the unreachable sentinel.
package arb_cycle_tracer_pkg;

  localparam int PKG_NODES    = 16;
  localparam int PKG_PRED_W   = $clog2(PKG_NODES);
  localparam int PKG_WEIGHT_W = 32;

  localparam logic [PKG_WEIGHT_W-1:0] PKG_INF_WEIGHT = 32'h777fffff;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SCAN_RD  = 3'd1,
    ST_SCAN_CHK = 3'd2,
    ST_WALK_RD  = 3'd3,
    ST_WALK     = 3'd4,
    ST_EMIT     = 3'd5,
    ST_EMIT_NX  = 3'd6,
    ST_FIN      = 3'd7
  } tracer_state_t;

  typedef struct packed {
    logic [PKG_PRED_W-1:0]   pred;
    logic [PKG_WEIGHT_W-1:0] weight;
  } vert_t;

endpackage

// File: rtl/arb_cycle_tracer_relax.sv
// relax_check: combinational Bellman-Ford relaxation test.
// Ports: i_svw/i_dvw source/dest weights, i_e edge, o_hit relaxes.
module relax_check
  import arb_cycle_tracer_pkg::*;
#(
  parameter int                   WEIGHT_W   = PKG_WEIGHT_W,
  parameter logic [WEIGHT_W-1:0]  INF_WEIGHT = WEIGHT_W'(PKG_INF_WEIGHT)
) (
  input  logic [WEIGHT_W-1:0] i_svw,
  input  logic [WEIGHT_W-1:0] i_dvw,
  input  logic [WEIGHT_W-1:0] i_e,
  output logic                o_hit
);

  logic signed [WEIGHT_W:0] w_sum;
  logic signed [WEIGHT_W:0] w_dvw;

  // One guard bit so svw+e cannot wrap.
  assign w_sum = $signed({i_svw[WEIGHT_W-1], i_svw})
               + $signed({i_e[WEIGHT_W-1], i_e});
  assign w_dvw = $signed({i_dvw[WEIGHT_W-1], i_dvw});

  assign o_hit = (i_e != '0)
              && (i_svw != INF_WEIGHT)
              && (w_sum < w_dvw);

endmodule

// File: rtl/arb_cycle_tracer.sv
// arb_cycle_tracer: finds a negative cycle in the relaxed vertex
// matrix, walks into it and streams its vertices (valid/ready).
// Ports: start; vertmat/adjmat read ports (1-cycle latency);
// cyc_valid/ready/vertex/last stream; busy, done, cycle_found,
// overflow, cycle_weight.
// Option: define ARB_CYCLE_TRACER_PROFIT_EN to sum the cycle's
// edge weights into cycle_weight (tied to 0 otherwise).
module arb_cycle_tracer
  import arb_cycle_tracer_pkg::*;
#(
  parameter int                   NODES      = PKG_NODES,
  parameter int                   PRED_W     = $clog2(NODES),
  parameter int                   WEIGHT_W   = PKG_WEIGHT_W,
  parameter logic [WEIGHT_W-1:0]  INF_WEIGHT = WEIGHT_W'(PKG_INF_WEIGHT)
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic [PRED_W+WEIGHT_W-1:0]   vertmat_q_a,
  input  logic [PRED_W+WEIGHT_W-1:0]   vertmat_q_b,
  input  logic [WEIGHT_W-1:0]          adjmat_q,
  output logic [PRED_W-1:0]            vertmat_addr_a,
  output logic [PRED_W-1:0]            vertmat_addr_b,
  output logic [PRED_W-1:0]            adjmat_row_addr,
  output logic [PRED_W-1:0]            adjmat_col_addr,
  output logic                         cyc_valid,
  input  logic                         cyc_ready,
  output logic [PRED_W-1:0]            cyc_vertex,
  output logic                         cyc_last,
  output logic                         busy,
  output logic                         done,
  output logic                         cycle_found,
  output logic                         overflow,
  output logic [WEIGHT_W+PRED_W-1:0]   cycle_weight
);

  localparam int CNT_W = $clog2(NODES + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(NODES);
  localparam logic [PRED_W-1:0] LAST_IX = PRED_W'(NODES - 1);

  // Pre-read cycles before a beat is shown: vertex data, and with
  // profit tracking also the edge read addressed by pred(x).
`ifdef ARB_CYCLE_TRACER_PROFIT_EN
  localparam logic [1:0] PH_RDY = 2'd3;
`else
  localparam logic [1:0] PH_RDY = 2'd1;
`endif

  tracer_state_t      r_state;
  logic [PRED_W-1:0]  r_u;
  logic [PRED_W-1:0]  r_v;
  logic [PRED_W-1:0]  r_x;
  logic [PRED_W-1:0]  r_start_v;
  logic [CNT_W-1:0]   r_step;
  logic [1:0]         r_ph;
  logic [PRED_W-1:0]  r_addr_a;
  logic [PRED_W-1:0]  r_addr_b;
  logic [PRED_W-1:0]  r_row;
  logic [PRED_W-1:0]  r_col;
  logic               r_found;
  logic               r_ovf;

  logic [PRED_W-1:0]   w_qa_pred;
  logic [WEIGHT_W-1:0] w_qa_w;
  logic [WEIGHT_W-1:0] w_qb_w;
  logic                w_hit;
  logic                w_emit_rdy;
  logic [PRED_W-1:0]   w_u_nx;
  logic [PRED_W-1:0]   w_v_nx;
  logic [CNT_W-1:0]    w_step_nx;
  logic                w_unused_qb;

  assign w_qa_pred = vertmat_q_a[PRED_W+WEIGHT_W-1 -: PRED_W];
  assign w_qa_w    = vertmat_q_a[WEIGHT_W-1:0];
  assign w_qb_w    = vertmat_q_b[WEIGHT_W-1:0];
  assign w_unused_qb = ^vertmat_q_b[PRED_W+WEIGHT_W-1 -: PRED_W];

  relax_check #(
    .WEIGHT_W   (WEIGHT_W),
    .INF_WEIGHT (INF_WEIGHT)
  ) u_relax (
    .i_svw (w_qa_w),
    .i_dvw (w_qb_w),
    .i_e   (adjmat_q),
    .o_hit (w_hit)
  );

  assign w_v_nx    = (r_v == LAST_IX) ? '0 : r_v + 1'b1;
  assign w_u_nx    = (r_v == LAST_IX) ? r_u + 1'b1 : r_u;
  assign w_step_nx = r_step + 1'b1;
  assign w_emit_rdy = (r_state == ST_EMIT) && (r_ph == PH_RDY);

`ifdef ARB_CYCLE_TRACER_PROFIT_EN
  logic [WEIGHT_W+PRED_W-1:0] r_wsum;
  logic [WEIGHT_W+PRED_W-1:0] w_e_ext;

  assign w_e_ext = {{PRED_W{adjmat_q[WEIGHT_W-1]}}, adjmat_q};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wsum <= '0;
    end else if (r_state == ST_IDLE && start) begin
      r_wsum <= '0;
    end else if (w_emit_rdy && cyc_ready) begin
      r_wsum <= r_wsum + w_e_ext;
    end
  end

  assign cycle_weight = r_wsum;
`else
  assign cycle_weight = '0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_u       <= '0;
      r_v       <= '0;
      r_x       <= '0;
      r_start_v <= '0;
      r_step    <= '0;
      r_ph      <= '0;
      r_addr_a  <= '0;
      r_addr_b  <= '0;
      r_row     <= '0;
      r_col     <= '0;
      r_found   <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_u      <= '0;
            r_v      <= '0;
            r_addr_a <= '0;
            r_addr_b <= '0;
            r_row    <= '0;
            r_col    <= '0;
            r_found  <= 1'b0;
            r_ovf    <= 1'b0;
            r_state  <= ST_SCAN_RD;
          end
        end
        ST_SCAN_RD: begin
          r_state <= ST_SCAN_CHK;
        end
        ST_SCAN_CHK: begin
          if (w_hit) begin
            r_x      <= r_v;
            r_addr_a <= r_v;
            r_step   <= '0;
            r_row    <= '0;
            r_col    <= '0;
            r_state  <= ST_WALK_RD;
          end else if (r_u == LAST_IX && r_v == LAST_IX) begin
            r_found <= 1'b0;
            r_row   <= '0;
            r_col   <= '0;
            r_state <= ST_FIN;
          end else begin
            r_u      <= w_u_nx;
            r_v      <= w_v_nx;
            r_addr_a <= w_u_nx;
            r_addr_b <= w_v_nx;
            r_row    <= w_u_nx;
            r_col    <= w_v_nx;
            r_state  <= ST_SCAN_RD;
          end
        end
        ST_WALK_RD: begin
          r_state <= ST_WALK;
        end
        ST_WALK: begin
          // NODES pred hops from any vertex land inside the cycle.
          r_x      <= w_qa_pred;
          r_addr_a <= w_qa_pred;
          if (w_step_nx == CNT_MAX) begin
            r_start_v <= w_qa_pred;
            r_step    <= '0;
            r_ph      <= '0;
            r_state   <= ST_EMIT;
          end else begin
            r_step  <= w_step_nx;
            r_state <= ST_WALK_RD;
          end
        end
        ST_EMIT: begin
          if (r_ph != PH_RDY) begin
            r_ph <= r_ph + 2'd1;
`ifdef ARB_CYCLE_TRACER_PROFIT_EN
            if (r_ph == 2'd1) begin
              r_row <= w_qa_pred;
              r_col <= r_x;
            end
`endif
          end else if (cyc_ready) begin
            r_step  <= w_step_nx;
            r_state <= ST_EMIT_NX;
          end
        end
        ST_EMIT_NX: begin
          if (w_qa_pred == r_start_v) begin
            r_found <= 1'b1;
            r_state <= ST_FIN;
          end else if (r_step == CNT_MAX) begin
            r_ovf   <= 1'b1;
            r_found <= 1'b0;
            r_state <= ST_FIN;
          end else begin
            r_x      <= w_qa_pred;
            r_addr_a <= w_qa_pred;
            r_ph     <= '0;
            r_state  <= ST_EMIT;
          end
        end
        ST_FIN: begin
          r_addr_a <= '0;
          r_addr_b <= '0;
          r_row    <= '0;
          r_col    <= '0;
          r_state  <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign vertmat_addr_a  = r_addr_a;
  assign vertmat_addr_b  = r_addr_b;
  assign adjmat_row_addr = r_row;
  assign adjmat_col_addr = r_col;

  assign cyc_valid   = w_emit_rdy;
  assign cyc_vertex  = w_emit_rdy ? r_x : '0;
  // Lookahead: q_a holds x's word, so pred(x) is already known.
  assign cyc_last    = w_emit_rdy && (w_qa_pred == r_start_v);
  assign busy        = (r_state != ST_IDLE);
  assign done        = (r_state == ST_FIN);
  assign cycle_found = r_found;
  assign overflow    = r_ovf;

endmodule

// File: tb/tb_arb_cycle_tracer.sv
// Scoreboard bench for arb_cycle_tracer with NODES=4.
// Synchronous memory models drive vertmat/adjmat read ports.
module tb_arb_cycle_tracer;

  localparam int N  = 4;
  localparam int PW = 2;
  localparam int WW = 32;
  localparam logic [WW-1:0] INF = 32'h777fffff;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic [PW+WW-1:0]  q_a, q_b;
  logic [WW-1:0]     adj_q;
  logic [PW-1:0]     addr_a, addr_b, row, col;
  logic              cyc_valid;
  logic              cyc_ready = 1'b1;
  logic [PW-1:0]     cyc_vertex;
  logic              cyc_last, busy, done, cycle_found, overflow;
  logic [WW+PW-1:0]  cycle_weight;

  logic [PW+WW-1:0]  vm [N];
  logic [WW-1:0]     am [N][N];

  typedef struct packed {
    logic [PW-1:0] v;
    logic          last;
  } beat_t;

  typedef struct packed {
    logic          found;
    logic          ovf;
    logic [WW+PW-1:0] w;
  } fin_t;

  beat_t exp_beats[$];
  fin_t  exp_fin[$];

  int vectors = 0;
  int miscompares = 0;
  logic rdy_mode = 1'b0;
  logic [3:0] rdy_pat = 4'b1001;
  int rdy_idx = 0;

  always #5 clk = ~clk;

  arb_cycle_tracer #(.NODES(N)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .start           (start),
    .vertmat_q_a     (q_a),
    .vertmat_q_b     (q_b),
    .adjmat_q        (adj_q),
    .vertmat_addr_a  (addr_a),
    .vertmat_addr_b  (addr_b),
    .adjmat_row_addr (row),
    .adjmat_col_addr (col),
    .cyc_valid       (cyc_valid),
    .cyc_ready       (cyc_ready),
    .cyc_vertex      (cyc_vertex),
    .cyc_last        (cyc_last),
    .busy            (busy),
    .done            (done),
    .cycle_found     (cycle_found),
    .overflow        (overflow),
    .cycle_weight    (cycle_weight)
  );

  always @(posedge clk) begin
    q_a   <= vm[addr_a];
    q_b   <= vm[addr_b];
    adj_q <= am[row][col];
  end

  initial begin : ready_drv
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode) begin
        cyc_ready = rdy_pat[rdy_idx];
        rdy_idx = (rdy_idx + 1) % 4;
      end else begin
        cyc_ready = 1'b1;
      end
    end
  end

  initial begin : monitor
    beat_t eb;
    fin_t  ef;
    logic  stalled;
    logic [PW-1:0] st_v;
    logic  st_l;
    stalled = 1'b0;
    st_v = '0;
    st_l = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          vectors++;
          if (!cyc_valid || cyc_vertex !== st_v || cyc_last !== st_l) begin
            miscompares++;
            $display("FAIL stall_hold: got v=%b vtx=%0d last=%b want v=1 vtx=%0d last=%b",
                     cyc_valid, cyc_vertex, cyc_last, st_v, st_l);
          end
        end
        stalled = cyc_valid && !cyc_ready;
        st_v = cyc_vertex;
        st_l = cyc_last;
        if (cyc_valid && cyc_ready) begin
          vectors++;
          if (exp_beats.size() == 0) begin
            miscompares++;
            $display("FAIL beat_extra: got vtx=%0d last=%b want no beat",
                     cyc_vertex, cyc_last);
          end else begin
            eb = exp_beats.pop_front();
            if (cyc_vertex !== eb.v || cyc_last !== eb.last) begin
              miscompares++;
              $display("FAIL beat: got vtx=%0d last=%b want vtx=%0d last=%b",
                       cyc_vertex, cyc_last, eb.v, eb.last);
            end
          end
        end
        if (done) begin
          vectors++;
          if (exp_fin.size() == 0) begin
            miscompares++;
            $display("FAIL done_extra: got done=1 want no done");
          end else begin
            ef = exp_fin.pop_front();
            if (cycle_found !== ef.found || overflow !== ef.ovf ||
                cycle_weight !== ef.w) begin
              miscompares++;
              $display("FAIL done_flags: got found=%b ovf=%b w=%h want found=%b ovf=%b w=%h",
                       cycle_found, overflow, cycle_weight,
                       ef.found, ef.ovf, ef.w);
            end
          end
        end
      end
    end
  end

  function automatic logic [WW+PW-1:0] wexp(input int w);
`ifdef ARB_CYCLE_TRACER_PROFIT_EN
    return (WW+PW)'(w);
`else
    return (WW+PW)'(w * 0);
`endif
  endfunction

  function automatic logic [PW+WW-1:0] word(input int p, input logic [WW-1:0] w);
    logic [PW-1:0] pp;
    pp = PW'(p);
    return {pp, w};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < N; i++) begin
      vm[i] = word(0, INF);
      for (int j = 0; j < N; j++) am[i][j] = '0;
    end
  endtask

  task automatic load_tri();
    clear_mem();
    vm[0] = word(2, -32'sd3);
    vm[1] = word(0, -32'sd4);
    vm[2] = word(1, -32'sd5);
    am[0][1] = -32'sd1;
    am[1][2] = -32'sd1;
    am[2][0] = -32'sd1;
  endtask

  task automatic push_beat(input int v, input logic l);
    beat_t b;
    b.v = PW'(v);
    b.last = l;
    exp_beats.push_back(b);
  endtask

  task automatic push_fin(input logic f, input logic o, input int w);
    fin_t e;
    e.found = f;
    e.ovf = o;
    e.w = wexp(w);
    exp_fin.push_back(e);
  endtask

  task automatic run_trace(input logic corrupt, output int cyc);
    logic did;
    did = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (corrupt && cyc_valid && !did) begin
        vm[1] = word(2, -32'sd1);
        did = 1'b1;
      end
    end
    vectors++;
    if (!done) begin
      miscompares++;
      $display("FAIL done_timeout: got no done want done within 3000 cycles");
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (exp_beats.size() != 0 || exp_fin.size() != 0) begin
      miscompares++;
      $display("FAIL queue_drain: got %0d beats %0d fins left want 0",
               exp_beats.size(), exp_fin.size());
    end
  endtask

  function automatic logic [31:0] out_bits();
    return 32'({addr_a, addr_b, row, col, cyc_valid, cyc_vertex,
                cyc_last, busy, done, cycle_found, overflow})
         | 32'(|cycle_weight);
  endfunction

  initial begin : stim
    int cyc;
    clear_mem();
    repeat (3) @(negedge clk);
    vectors++;
    if (out_bits() !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_state: got %h want 0", out_bits());
    end
    reset_n = 1'b1;
    @(negedge clk);

    // No edges: full scan, nothing found.
    clear_mem();
    vm[0] = word(0, 32'd0);
    push_fin(1'b0, 1'b0, 0);
    run_trace(1'b0, cyc);
    vectors++;
    if (cyc != 2 * N * N) begin
      miscompares++;
      $display("FAIL scan_cycles: got %0d want %0d", cyc, 2 * N * N);
    end

    // Three-cycle 0->1->2->0.
    load_tri();
    push_beat(2, 1'b0);
    push_beat(1, 1'b0);
    push_beat(0, 1'b1);
    push_fin(1'b1, 1'b0, -3);
    run_trace(1'b0, cyc);

    // Same with back-pressure.
    rdy_idx = 0;
    rdy_mode = 1'b1;
    push_beat(2, 1'b0);
    push_beat(1, 1'b0);
    push_beat(0, 1'b1);
    push_fin(1'b1, 1'b0, -3);
    run_trace(1'b0, cyc);
    rdy_mode = 1'b0;

    // Self-loop on vertex 2.
    clear_mem();
    vm[2] = word(2, 32'd0);
    am[2][2] = -32'sd5;
    push_beat(2, 1'b1);
    push_fin(1'b1, 1'b0, -5);
    run_trace(1'b0, cyc);

    // Four-cycle whose chain gets broken mid-emit.
    clear_mem();
    vm[0] = word(3, 32'd0);
    vm[1] = word(0, -32'sd1);
    vm[2] = word(1, -32'sd2);
    vm[3] = word(2, -32'sd3);
    am[0][1] = -32'sd1;
    am[1][2] = -32'sd1;
    am[2][3] = -32'sd1;
    am[3][0] = -32'sd1;
    push_beat(0, 1'b0);
    push_beat(3, 1'b0);
    push_beat(2, 1'b0);
    push_beat(1, 1'b0);
    push_fin(1'b0, 1'b1, -3);
    run_trace(1'b1, cyc);

    // Reset during the walk, then a clean retrace.
    load_tri();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL busy_walk: got %b want 1", busy);
    end
    reset_n = 1'b0;
    #1;
    vectors++;
    if (out_bits() !== 32'd0) begin
      miscompares++;
      $display("FAIL abort_reset: got %h want 0", out_bits());
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    push_beat(2, 1'b0);
    push_beat(1, 1'b0);
    push_beat(0, 1'b1);
    push_fin(1'b1, 1'b0, -3);
    run_trace(1'b0, cyc);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/arb_cycle_tracer.md
Name: arb_cycle_tracer

Overview:
Read-side consumer of the vertex matrix that the Bellman-Ford relaxation engine writes. After relaxation completes, it does three things:
- Runs one extra relaxation pass, read-only, to detect a negative cycle (an arbitrage opportunity).
- Walks predecessor links until it is guaranteed to be inside that cycle.
- Streams the cycle's vertex indices out over a valid/ready interface to the order-generation logic.

It never writes vertmat or adjmat.

Parameters:
NODES, 16, number of vertices (currencies); must be ≥2.
PRED_W, $clog2(NODES), vertex index width.
WEIGHT_W, 32, signed edge/vertex weight width.
INF_WEIGHT, 32'h777fffff, unreachable-vertex sentinel as written during setup.

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse; begin trace (sampled only in IDLE)
vertmat_q_a  in  PRED_W+WEIGHT_W  read data port A, {pred, weight}
vertmat_q_b  in  PRED_W+WEIGHT_W  read data port B, {pred, weight}
adjmat_q  in  WEIGHT_W  edge weight at (row, col); 0 = no edge
vertmat_addr_a  out  PRED_W  read address port A
vertmat_addr_b  out  PRED_W  read address port B
adjmat_row_addr  out  PRED_W  edge source
adjmat_col_addr  out  PRED_W  edge destination
cyc_valid  out  1  cyc_vertex valid
cyc_ready  in  1  downstream accepts
cyc_vertex  out  PRED_W  cycle vertex index
cyc_last  out  1  final vertex of cycle
busy  out  1  high outside IDLE
done  out  1  one-cycle pulse at completion
cycle_found  out  1  valid with done; 1 if a negative cycle was found
overflow  out  1  valid with done; emit exceeded NODES vertices
cycle_weight  out  WEIGHT_W+PRED_W  summed cycle edge weight (optional feature)

Behaviour:
- Reset (asynchronous, reset_n=0):
  - state=IDLE.
  - All outputs 0, including all addresses.
  - Internal indices u, v, x, start_v and the step counter all 0.
  - Reset asserted mid-operation aborts immediately; no done pulse.
- Memory latency: data is valid exactly 1 cycle after the address is driven. Every read therefore takes a RD (address) state followed by a USE state.
- Addresses are registered outputs.
- States and transitions:
  - IDLE: on start, u=0, v=0, go to SCAN_RD.
  - SCAN_RD:
    - Drive addr_a=u, addr_b=v, adjmat_row_addr=u, adjmat_col_addr=v.
    - Next state SCAN_CHK.
  - SCAN_CHK: with svw=q_a weight, dvw=q_b weight, e=adjmat_q:
    - Compute svw+e at WEIGHT_W+1 bits, signed.
    - Hit = (e≠0) && (svw≠INF_WEIGHT) && (svw+e < dvw), compared sign-extended.
    - On hit: x=v, step=0, go to WALK_RD.
    - On no hit: advance v, wrapping to 0 and incrementing u.
    - If u=v=NODES-1 was the last pair checked: cycle_found=0, go to FIN.
    - Otherwise go to SCAN_RD.
    - Full scan = NODES² pairs, 2 cycles each.
  - WALK_RD: addr_a=x, go to WALK.
  - WALK:
    - x=pred(q_a), step++.
    - When step reaches NODES: start_v=x, count=0, go to EMIT.
    - Otherwise go to WALK_RD.
  - EMIT:
    - cyc_valid=1, cyc_vertex=x, addr_a=x.
    - Hold all three stable until cyc_ready; valid must not drop before the handshake.
    - On handshake: count++, go to EMIT_NX.
  - EMIT_NX:
    - x=pred(q_a).
    - If x==start_v: the previous beat was the last. cyc_last was already asserted on it via a one-read lookahead, so the emit sequence is: EMIT reads pred, and cyc_last = (pred(x)==start_v).
    - Go to FIN with cycle_found=1.
    - Else if count==NODES: overflow=1, cycle_found=0, go to FIN.
    - Else go to EMIT.
  - FIN: done=1 for one cycle, go to IDLE.
- Lookahead detail:
  - In EMIT, cyc_valid rises only after q_a for x is valid; one internal pre-read cycle is allowed per vertex.
  - cyc_last is 1 iff pred(x)==start_v.
- Emission order: start_v, pred(start_v), pred(pred(start_v)), …, reverse of trade direction. A self-loop cycle emits one beat with cyc_last=1.
- cycle_found and overflow hold their values until the next start.
- Start while busy: ignored.

Optional Feature:
ARB_CYCLE_TRACER_PROFIT_EN
- Defined:
  - During EMIT, adjmat_row_addr=pred(x) and adjmat_col_addr=x.
  - Each accepted beat adds sign-extended adjmat_q to cycle_weight; the sum is cleared on start.
  - Final value is valid at done.
- Undefined:
  - cycle_weight is tied to 0.
  - The adjmat address ports are held at 0 outside the SCAN states.

Decomposition:
- Shared package:
  - tracer_state_t enum.
  - Vertex word struct {pred[PRED_W], weight[WEIGHT_W]}.
  - INF_WEIGHT constant.
  - Widths, kept consistent with the existing NODES/PRED/WEIGHT constants.
- One natural sub-module: relax_check, a combinational signed compare (svw, dvw, e → hit) shared with any future relaxation logic.

Test Plan:
- 4 nodes, weights all 0/INF (no edges) → done after 2·16 scan cycles, cycle_found=0, no cyc_valid.
- 3-cycle 0→1→2→0, edges -1 each, relaxed vertmat preloaded → 3 beats, vertices {x, pred(x), pred(pred(x))} covering {0,1,2}, cyc_last only on the 3rd, cycle_found=1.
- Same as the 3-cycle case with cyc_ready toggled 1-0-0-1 → cyc_vertex/valid stable while stalled, same 3 beats.
- Self-loop on vertex 2 with weight -5, pred[2]=2 → one beat, cyc_vertex=2, cyc_last=1; with PROFIT_EN, cycle_weight=-5.
- Corrupt pred chain never returning to start_v, NODES=4 → 4 beats, then overflow=1, cycle_found=0.
- reset_n pulsed low during WALK → all outputs 0 within the same cycle, IDLE; a new start then traces correctly.
